// File: rtl/arb_pkg.sv
// Shared types and helpers for the hold-until-release arbiter:
// FSM state encoding, width rules and the one-hot to index encoder.
package arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    function automatic int grt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int max_hold);
        return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
    endfunction

    // OR-based encoder: exact for one-hot inputs, zero for an all-zero input.
    function automatic int onehot_to_index(input logic [63:0] onehot);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (onehot[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_timeout_arbiter_if.sv
// Request/release/mask inputs and grant outputs of the arbiter,
// bundled so requesters and the arbiter share one port.
interface rr_timeout_arbiter_if import arb_pkg::*; #(
    parameter int NUM_ENTRY = 4
);
    localparam int GRT_W = grt_w(NUM_ENTRY);

    logic [NUM_ENTRY-1:0] I_Req;
    logic [NUM_ENTRY-1:0] I_Rls;
    logic [NUM_ENTRY-1:0] I_Mask;
    logic [GRT_W-1:0]     O_Grt;
    logic [NUM_ENTRY-1:0] O_Vld;
    logic [NUM_ENTRY-1:0] O_Rvk;

    modport master (output I_Req, I_Rls, I_Mask, input O_Grt, O_Vld, O_Rvk);
    modport slave  (input I_Req, I_Rls, I_Mask, output O_Grt, O_Vld, O_Rvk);

endinterface

// File: rtl/rr_pick.sv
// Combinational winner selection: fixed priority or round-robin from ptr,
// using a double-width vector so the wrap-around needs no modulo logic.
module rr_pick import arb_pkg::*; #(
    parameter int NUM_ENTRY = 4,
    parameter int PTR_W     = grt_w(NUM_ENTRY)
) (
    input  logic [NUM_ENTRY-1:0] elig,
    input  logic [PTR_W-1:0]     ptr,
    input  logic                 rr_mode,
    output logic [NUM_ENTRY-1:0] winner
);
    localparam int W2 = 2 * NUM_ENTRY;

    logic [NUM_ENTRY-1:0] thermo;
    logic [W2-1:0]        dbl;
    logic [W2-1:0]        lowest;

    // Lower half keeps only entries at or after the pointer; the upper half
    // holds the full vector and catches the wrap when the lower half is empty.
    for (genvar gi = 0; gi < NUM_ENTRY; gi++) begin : g_thermo
        assign thermo[gi] = !rr_mode || (gi >= int'(ptr));
    end

    assign dbl    = {elig, elig & thermo};
    assign lowest = dbl & (~dbl + W2'(1));
    assign winner = lowest[NUM_ENTRY-1:0] | lowest[W2-1:NUM_ENTRY];

endmodule

// File: rtl/rr_timeout_arbiter.sv
// Hold-until-release arbiter: one owner at a time, fixed or round-robin pick,
// masking, and an optional hold limit that revokes a stuck owner.
module rr_timeout_arbiter import arb_pkg::*; #(
    parameter int NUM_ENTRY = 4,
    parameter int RR_MODE   = 1,
    parameter int MAX_HOLD  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    rr_timeout_arbiter_if.slave   bus
);
    localparam int GRT_W = grt_w(NUM_ENTRY);
    localparam int CNT_W = cnt_w(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    arb_state_t           state_reg, state_next;
    logic [NUM_ENTRY-1:0] vld_reg, vld_next;
    logic [NUM_ENTRY-1:0] rvk_reg, rvk_next;
    logic [NUM_ENTRY-1:0] skip_reg, skip_next;
    logic [GRT_W-1:0]     ptr_reg, ptr_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;

    logic [NUM_ENTRY-1:0] elig, elig_skip, pick_elig, winner;
    logic [GRT_W-1:0]     win_idx;
    logic                 owner_rls;
    logic                 hold_expired;

    assign elig      = bus.I_Req & ~bus.I_Rls & ~bus.I_Mask;
    assign elig_skip = elig & ~skip_reg;
    // A just-revoked entry that is the only candidate gets the grant back.
    assign pick_elig = (elig_skip != '0) ? elig_skip : elig;

    rr_pick #(
        .NUM_ENTRY (NUM_ENTRY),
        .PTR_W     (GRT_W)
    ) u_pick (
        .elig    (pick_elig),
        .ptr     (ptr_reg),
        .rr_mode (RR_MODE != 0),
        .winner  (winner)
    );

    assign win_idx      = GRT_W'(onehot_to_index(64'(winner)));
    assign owner_rls    = |(vld_reg & bus.I_Rls);
    assign hold_expired = (MAX_HOLD > 0) && (cnt_reg == HOLD_LAST);

    always_comb begin
        state_next = state_reg;
        vld_next   = vld_reg;
        rvk_next   = '0;
        skip_next  = skip_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                skip_next = '0;
                if (winner != '0) begin
                    state_next = ARB_BUSY;
                    vld_next   = winner;
                    cnt_next   = '0;
                    ptr_next   = (win_idx == GRT_W'(NUM_ENTRY - 1)) ? '0 : win_idx + GRT_W'(1);
                end
            end
            ARB_BUSY: begin
                // Release is checked first so it wins over a coincident timeout.
                if (owner_rls) begin
                    state_next = ARB_IDLE;
                    vld_next   = '0;
                end else if (hold_expired) begin
                    state_next = ARB_IDLE;
                    vld_next   = '0;
                    rvk_next   = vld_reg;
                    skip_next  = vld_reg;
                end else if (cnt_reg != HOLD_LAST) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = ARB_IDLE;
                vld_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
            vld_reg   <= '0;
            rvk_reg   <= '0;
            skip_reg  <= '0;
            ptr_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            vld_reg   <= vld_next;
            rvk_reg   <= rvk_next;
            skip_reg  <= skip_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.O_Vld = vld_reg;
    assign bus.O_Rvk = rvk_reg;
    assign bus.O_Grt = GRT_W'(onehot_to_index(64'(vld_reg)));

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Bench for rr_timeout_arbiter: six configurations share one stimulus stream
// and are each compared every cycle against an index-based reference model.
module tb_rr_timeout_arbiter;
    import arb_pkg::*;

    localparam int NU = 6;
    localparam int U_N  [NU] = '{4, 4, 4, 4, 1, 5};
    localparam int U_RR [NU] = '{0, 1, 1, 1, 1, 1};
    localparam int U_MH [NU] = '{0, 0, 3, 2, 2, 0};

    typedef struct {
        logic [7:0] req;
        logic [7:0] rls;
        logic [7:0] mask;
        logic [7:0] exp_vld;
        logic [7:0] exp_grt;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req   = '0;
    logic [7:0] rls   = '0;
    logic [7:0] mask  = '0;
    logic [7:0] vld_o [NU];
    logic [7:0] rvk_o [NU];
    logic [7:0] grt_o [NU];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int m_owner [NU];
    int m_cnt   [NU];
    int m_ptr   [NU];
    int m_skip  [NU];
    int m_rvk   [NU];

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < NU; gi++) begin : g_dut
        rr_timeout_arbiter_if #(.NUM_ENTRY(U_N[gi])) bus ();
        assign bus.I_Req  = req[U_N[gi]-1:0];
        assign bus.I_Rls  = rls[U_N[gi]-1:0];
        assign bus.I_Mask = mask[U_N[gi]-1:0];
        rr_timeout_arbiter #(
            .NUM_ENTRY (U_N[gi]),
            .RR_MODE   (U_RR[gi]),
            .MAX_HOLD  (U_MH[gi])
        ) u_dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );
        assign vld_o[gi] = 8'(bus.O_Vld);
        assign rvk_o[gi] = 8'(bus.O_Rvk);
        assign grt_o[gi] = 8'(bus.O_Grt);
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: owner index, cycles held, pointer, skipped index; -1 = none.
    task automatic model_edge();
        int n;
        int e;
        int k;
        for (int u = 0; u < NU; u++) begin
            n = U_N[u];
            m_rvk[u] = -1;
            if (reset) begin
                m_owner[u] = -1;
                m_cnt[u]   = 0;
                m_ptr[u]   = 0;
                m_skip[u]  = -1;
            end else if (m_owner[u] >= 0) begin
                if (rls[m_owner[u]]) begin
                    m_owner[u] = -1;
                end else if (U_MH[u] > 0 && m_cnt[u] == U_MH[u] - 1) begin
                    m_rvk[u]   = m_owner[u];
                    m_skip[u]  = m_owner[u];
                    m_owner[u] = -1;
                end else begin
                    m_cnt[u]++;
                end
            end else begin
                e = int'(req & ~rls & ~mask) & ((1 << n) - 1);
                if (m_skip[u] >= 0 && (e & ~(1 << m_skip[u])) != 0)
                    e = e & ~(1 << m_skip[u]);
                m_skip[u] = -1;
                for (int off = 0; off < n; off++) begin
                    k = (U_RR[u] != 0) ? (m_ptr[u] + off) % n : off;
                    if (((e >> k) & 1) != 0) begin
                        m_owner[u] = k;
                        m_cnt[u]   = 0;
                        m_ptr[u]   = (k + 1) % n;
                        break;
                    end
                end
            end
        end
    endtask

    task automatic step();
        logic [7:0] ev, er, eg;
        @(posedge clock);
        model_edge();
        #1;
        cyc++;
        for (int u = 0; u < NU; u++) begin
            ev = (m_owner[u] >= 0) ? 8'(1 << m_owner[u]) : 8'h00;
            eg = (m_owner[u] >= 0) ? 8'(m_owner[u]) : 8'h00;
            er = (m_rvk[u] >= 0) ? 8'(1 << m_rvk[u]) : 8'h00;
            check($sformatf("model_u%0d_cyc%0d grt/vld/rvk", u, cyc),
                  {grt_o[u], vld_o[u], rvk_o[u]}, {eg, ev, er});
            check($sformatf("onehot_u%0d_cyc%0d", u, cyc),
                  24'(($onehot0(vld_o[u]) && ((vld_o[u] & rvk_o[u]) == 8'h00)) ? 1 : 0), 24'd1);
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] l, input logic [7:0] m);
        req  = r;
        rls  = l;
        mask = m;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(8'h00, 8'h00, 8'h00);
        step();
        reset = 1'b0;
    endtask

    initial begin
        vec_t tbl [11];
        int   exp_idx;
        tbl[0]  = '{8'b1010, 8'b0000, 8'b0000, 8'b0010, 8'd1};
        tbl[1]  = '{8'b1000, 8'b0010, 8'b0000, 8'b0000, 8'd0};
        tbl[2]  = '{8'b1000, 8'b0000, 8'b0000, 8'b1000, 8'd3};
        tbl[3]  = '{8'b1000, 8'b1000, 8'b0000, 8'b0000, 8'd0};
        tbl[4]  = '{8'b0011, 8'b0000, 8'b0001, 8'b0010, 8'd1};
        tbl[5]  = '{8'b0011, 8'b0000, 8'b0010, 8'b0010, 8'd1};
        tbl[6]  = '{8'b0000, 8'b0000, 8'b0000, 8'b0010, 8'd1};
        tbl[7]  = '{8'b0000, 8'b0011, 8'b0000, 8'b0000, 8'd0};
        tbl[8]  = '{8'b0001, 8'b0000, 8'b0000, 8'b0001, 8'd0};
        tbl[9]  = '{8'b0001, 8'b0100, 8'b0000, 8'b0001, 8'd0};
        tbl[10] = '{8'b0000, 8'b0001, 8'b0000, 8'b0000, 8'd0};

        reset = 1'b1;
        step();
        step();
        for (int u = 0; u < NU; u++)
            check($sformatf("reset_state_u%0d", u), {grt_o[u], vld_o[u], rvk_o[u]}, 24'h0);
        reset = 1'b0;

        // Fixed priority, masking and held-grant rules on unit 0.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].req, tbl[i].rls, tbl[i].mask);
            step();
            check($sformatf("tbl%0d vld", i), 24'(vld_o[0]), 24'(tbl[i].exp_vld));
            check($sformatf("tbl%0d grt", i), 24'(grt_o[0]), 24'(tbl[i].exp_grt));
            check($sformatf("tbl%0d rvk", i), 24'(rvk_o[0]), 24'h0);
        end

        // Round-robin fairness with one bubble between grants.
        do_reset();
        drive(8'h0F, 8'h00, 8'h00);
        step();
        for (int g = 0; g < 5; g++) begin
            exp_idx = g % 4;
            check($sformatf("rr_grant%0d", g), 24'(vld_o[1]), 24'(1 << exp_idx));
            step();
            check($sformatf("rr_hold%0d", g), 24'(vld_o[1]), 24'(1 << exp_idx));
            drive(8'h0F, 8'(1 << exp_idx), 8'h00);
            step();
            check($sformatf("rr_bubble%0d", g), 24'(vld_o[1]), 24'h0);
            drive(8'h0F, 8'h00, 8'h00);
            step();
        end

        // Timeout after three held cycles, then the revoked entry is skipped.
        do_reset();
        drive(8'b0101, 8'h00, 8'h00);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("to_hold%0d", c), 24'(vld_o[2]), 24'h1);
        end
        step();
        check("to_revoke", {vld_o[2], rvk_o[2]}, {8'h00, 8'h01});
        step();
        check("to_skip_grant", {vld_o[2], rvk_o[2]}, {8'h04, 8'h00});

        // Lone revoked requester is regranted.
        do_reset();
        drive(8'b0001, 8'h00, 8'h00);
        step();
        step();
        check("lone_hold", 24'(vld_o[3]), 24'h1);
        step();
        check("lone_revoke", {vld_o[3], rvk_o[3]}, {8'h00, 8'h01});
        step();
        check("lone_regrant", {vld_o[3], rvk_o[3]}, {8'h01, 8'h00});

        // Release in the timeout cycle: no revoke pulse.
        do_reset();
        drive(8'b0001, 8'h00, 8'h00);
        step();
        step();
        step();
        check("coll_hold", 24'(vld_o[2]), 24'h1);
        drive(8'h00, 8'b0001, 8'h00);
        step();
        check("coll_no_rvk", {vld_o[2], rvk_o[2]}, {8'h00, 8'h00});

        // Reset mid-grant drops ownership and rewinds the pointer.
        do_reset();
        drive(8'b0100, 8'h00, 8'h00);
        step();
        check("rst_mid_grant", 24'(vld_o[1]), 24'h4);
        reset = 1'b1;
        drive(8'h0F, 8'h00, 8'h00);
        step();
        check("rst_mid_clear", {vld_o[1], rvk_o[1]}, {8'h00, 8'h00});
        reset = 1'b0;
        step();
        check("rst_ptr_zero", 24'(vld_o[1]), 24'h1);

        // Five entries: pointer advance to 4 and wrap back to 0; single entry.
        do_reset();
        drive(8'h08, 8'h00, 8'h00);
        step();
        check("n5_grant3", {grt_o[5], vld_o[5]}, {8'd3, 8'h08});
        drive(8'h1F, 8'h08, 8'h00);
        step();
        drive(8'h1F, 8'h00, 8'h00);
        step();
        check("n5_grant4", {grt_o[5], vld_o[5]}, {8'd4, 8'h10});
        drive(8'h1F, 8'h10, 8'h00);
        step();
        drive(8'h1F, 8'h00, 8'h00);
        step();
        check("n5_wrap0", {grt_o[5], vld_o[5]}, {8'd0, 8'h01});
        do_reset();
        drive(8'h01, 8'h00, 8'h00);
        step();
        check("n1_grant", {grt_o[4], vld_o[4]}, {8'd0, 8'h01});

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            req   = 8'($urandom);
            rls   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            mask  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
